// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the fetch
// (imem) and data (dmem) ports; one transaction in flight, data-first priority.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t      state_q,      state_d;
  logic [3:0]  streak_q,     streak_d;
  logic        win_dmem_q,   win_dmem_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic        mem_read_q,   mem_read_d;
  logic        mem_write_q,  mem_write_d;
  logic [3:0]  mem_wmask_q,  mem_wmask_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;
  logic [31:0] imem_rdata_q, imem_rdata_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic        imem_resp_q,  imem_resp_d;
  logic        dmem_resp_q,  dmem_resp_d;

  logic        resp_cycle;
  logic        imem_req;
  logic        dmem_req;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    win_dmem_d   = win_dmem_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_resp_d  = 1'b0;
    dmem_resp_d  = 1'b0;

    // The requester still holds its request during its resp cycle, so no
    // grant is made while a resp pulse is on the outputs.
    resp_cycle = imem_resp_q | dmem_resp_q;
    imem_req   = imem_read & ~resp_cycle;
    dmem_req   = (dmem_read | dmem_write) & ~resp_cycle;

    unique case (state_q)
      IDLE: begin
        if (dmem_req && !(imem_req && streak_q == STREAK_MAX)) begin
          win_dmem_d  = 1'b1;
          mem_addr_d  = dmem_addr;
          mem_write_d = dmem_write;
          mem_read_d  = ~dmem_write;
          mem_wmask_d = dmem_write ? dmem_wmask : 4'b0000;
          mem_wdata_d = dmem_wdata;
          state_d     = BUSY;
          if (imem_read && streak_q < STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (imem_req) begin
          win_dmem_d  = 1'b0;
          mem_addr_d  = imem_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_wmask_d = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          streak_d    = 4'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (win_dmem_q) begin
            dmem_rdata_d = mem_write_q ? 32'h0000_0000 : mem_rdata;
          end else begin
            imem_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        imem_resp_d = ~win_dmem_q;
        dmem_resp_d = win_dmem_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      streak_q     <= 4'd0;
      win_dmem_q   <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wmask_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
      imem_rdata_q <= 32'h0000_0000;
      dmem_rdata_q <= 32'h0000_0000;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      win_dmem_q   <= win_dmem_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_resp_q  <= imem_resp_d;
      dmem_resp_q  <= dmem_resp_d;
    end
  end

  assign imem_rdata = imem_rdata_q;
  assign imem_resp  = imem_resp_q;
  assign dmem_rdata = dmem_rdata_q;
  assign dmem_resp  = dmem_resp_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-timestamp reference model.
module tb_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic [3:0]  dmem_wmask, mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_a [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_a[a] = w;
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          started = 0;
  bit          m_active = 0, m_win = 0, m_wr = 0;
  int          m_tg = 0, m_tm = -1, m_free = 0, m_streak = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_irdata = 0, m_drdata = 0;
  logic [3:0]  m_wmask = 0;
  bit          m_zero = 1, m_izero = 1, m_dzero = 1;
  bit          rec_en = 0;
  string       m_gseq = "";
  string       gseq = "";

  always @(negedge clk) begin
    bit e_stb, e_ir, e_dr, ir, dr;
    if (started) begin
      e_stb = m_active && cyc > m_tg && (m_tm < 0 || cyc <= m_tm);
      e_ir  = m_active && !m_win && m_tm >= 0 && cyc == m_tm + 2;
      e_dr  = m_active &&  m_win && m_tm >= 0 && cyc == m_tm + 2;
      chk("mem_read",  32'(mem_read),  32'(e_stb && !m_wr));
      chk("mem_write", 32'(mem_write), 32'(e_stb && m_wr));
      chk("imem_resp", 32'(imem_resp), 32'(e_ir));
      chk("dmem_resp", 32'(dmem_resp), 32'(e_dr));
      if (e_stb || m_zero) begin
        chk("mem_addr",  mem_addr, m_addr);
        chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      end
      if ((e_stb && m_wr) || m_zero) chk("mem_wdata", mem_wdata, m_wdata);
      if (e_ir || m_izero) chk("imem_rdata", imem_rdata, m_irdata);
      if (e_dr || m_dzero) chk("dmem_rdata", dmem_rdata, m_drdata);
    end
    if (rst) begin
      started  = 1;
      m_active = 0;
      m_free   = cyc + 1;
      m_streak = 0;
      m_addr = 0; m_wmask = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
      m_zero = 1; m_izero = 1; m_dzero = 1;
    end else if (started) begin
      if (m_active && m_tm < 0 && cyc > m_tg && mem_resp) begin
        m_tm = cyc;
        if (m_win) begin m_drdata = m_wr ? 32'h0 : mem_rdata; m_dzero = 0; end
        else begin m_irdata = mem_rdata; m_izero = 0; end
      end else if (m_active && m_tm >= 0 && cyc == m_tm + 2) begin
        m_active = 0;
        m_free   = cyc + 1;
      end else if (!m_active && cyc >= m_free) begin
        ir = imem_read;
        dr = dmem_read || dmem_write;
        if (dr && !(ir && m_streak == MAXS)) begin
          m_win = 1; m_wr = dmem_write; m_addr = dmem_addr;
          m_wmask = dmem_write ? dmem_wmask : 4'b0;
          m_wdata = dmem_wdata;
          if (ir && m_streak < MAXS) m_streak++;
          if (rec_en) m_gseq = {m_gseq, "D"};
        end else if (ir) begin
          m_win = 0; m_wr = 0; m_addr = imem_addr; m_wmask = 4'b0;
          m_streak = 0;
          if (rec_en) m_gseq = {m_gseq, "I"};
        end
        if (ir || dr) begin
          m_active = 1; m_tg = cyc; m_tm = -1; m_zero = 0;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver ----------------
  bit rand_mode = 0, spur_en = 0, prev_stb = 0, r_busy = 0, i_got = 0, d_got = 0;
  int lat_force = 1, r_lat = 1, r_cnt = 0;

  task automatic tick();
    bit stb;
    int k;
    @(posedge clk); #1;
    stb = mem_read || mem_write;
    mem_resp  = 1'b0;
    mem_rdata = $urandom;
    if (stb) begin
      if (!r_busy) begin
        r_busy = 1; r_cnt = 0;
        r_lat = (lat_force > 0) ? lat_force : $urandom_range(1, 5);
      end
      r_cnt++;
      if (r_cnt == r_lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rd(mem_addr);
        if (mem_write) wr(mem_addr, mem_wmask, mem_wdata);
      end
    end else begin
      r_busy = 0;
      if (spur_en && $urandom_range(0, 7) == 0) mem_resp = 1'b1;
    end
    if (rec_en && stb && !prev_stb) begin
      if (mem_addr == 32'h1000_0000) gseq = {gseq, "I"};
      else gseq = {gseq, "D"};
    end
    prev_stb = stb;
    if (rand_mode) begin
      rst = ($urandom_range(0, 399) == 0);
      if (i_got) begin imem_read = 0; i_got = 0; end
      if (!imem_read && $urandom_range(0, 2) == 0) begin
        imem_read = 1; imem_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (imem_resp) i_got = 1;
      if (d_got) begin dmem_read = 0; dmem_write = 0; d_got = 0; end
      if (!(dmem_read || dmem_write)) begin
        dmem_addr = $urandom; dmem_wdata = $urandom; dmem_wmask = 4'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          k = $urandom_range(0, 2);
          dmem_read = (k != 1); dmem_write = (k != 0);
        end
      end else if (m_active && m_win) begin
        dmem_addr = $urandom; dmem_wdata = $urandom;
      end
      if (dmem_resp) d_got = 1;
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_strobes"}, {28'h0, mem_read, mem_write, imem_resp, dmem_resp}, 32'h0);
    chk({nm, "_addr"}, mem_addr, 32'h0);
    chk({nm, "_wdata"}, mem_wdata, 32'h0);
    chk({nm, "_wmask"}, 32'(mem_wmask), 32'h0);
    chk({nm, "_irdata"}, imem_rdata, 32'h0);
    chk({nm, "_drdata"}, dmem_rdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    string exp_seq;
    rst = 1; imem_read = 1; imem_addr = 32'h0000_0040;
    dmem_addr = 0; dmem_read = 0; dmem_write = 0; dmem_wmask = 0; dmem_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    mem_a[32'h1000_0000] = 32'h0000_0013;

    // reset held two cycles with a fetch pending
    tick(); chk_quiet("rst_c1");
    tick(); rst = 0; chk_quiet("rst_c2");
    tick(); chk("rst_first_read", 32'(mem_read), 32'h1);
    tick(); chk("rst_read_drop", 32'(mem_read), 32'h0);
    tick(); chk("rst_first_resp", 32'(imem_resp), 32'h1);
    tick(); imem_read = 0;
    tick();

    // single fetch with a 1-cycle memory
    imem_addr = 32'h1000_0000; imem_read = 1;
    tick(); chk("fetch_read", 32'(mem_read), 32'h1); chk("fetch_addr", mem_addr, 32'h1000_0000);
    tick(); chk("fetch_read_c2", 32'(mem_read), 32'h0); chk("fetch_resp_c2", 32'(imem_resp), 32'h0);
    tick(); chk("fetch_resp", 32'(imem_resp), 32'h1); chk("fetch_rdata", imem_rdata, 32'h0000_0013);
    chk("fetch_dresp", 32'(dmem_resp), 32'h0);
    tick(); imem_read = 0;
    tick();

    // store with read also raised
    dmem_addr = 32'h2000_0004; dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF;
    dmem_write = 1; dmem_read = 1;
    tick();
    chk("st_write", 32'(mem_write), 32'h1); chk("st_read", 32'(mem_read), 32'h0);
    chk("st_addr", mem_addr, 32'h2000_0004); chk("st_wmask", 32'(mem_wmask), 32'h3);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); tick();
    chk("st_dresp", 32'(dmem_resp), 32'h1); chk("st_iresp", 32'(imem_resp), 32'h0);
    chk("st_drdata", dmem_rdata, 32'h0);
    tick(); dmem_read = 0; dmem_write = 0;
    chk("st_dresp_once", 32'(dmem_resp), 32'h0);
    tick();

    // 7-cycle memory latency, requester inputs toggled while busy
    lat_force = 7;
    dmem_addr = 32'h2000_0010; dmem_wmask = 4'b1100; dmem_wdata = 32'h1234_5678; dmem_write = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("vl_write", 32'(mem_write), 32'h1);
      chk("vl_addr", mem_addr, 32'h2000_0010);
      chk("vl_wmask", 32'(mem_wmask), 32'hC);
      chk("vl_wdata", mem_wdata, 32'h1234_5678);
      dmem_addr = $urandom; dmem_wdata = $urandom;
    end
    tick(); chk("vl_write_drop", 32'(mem_write), 32'h0); chk("vl_dresp_early", 32'(dmem_resp), 32'h0);
    tick(); chk("vl_dresp", 32'(dmem_resp), 32'h1);
    tick(); dmem_write = 0;
    tick();

    // reset while a fetch is outstanding, then a late mem_resp
    lat_force = 5;
    imem_addr = 32'h1000_0100; imem_read = 1;
    tick(); chk("rb_read", 32'(mem_read), 32'h1);
    tick(); rst = 1; imem_read = 0;
    tick(); rst = 0; chk_quiet("rb_after_rst");
    mem_resp = 1; mem_rdata = 32'hBAD0_BAD0;
    tick(); chk("rb_no_resp1", 32'(imem_resp), 32'h0); chk("rb_no_read1", 32'(mem_read), 32'h0);
    tick(); chk("rb_no_resp2", 32'(imem_resp), 32'h0); chk("rb_no_rdata", imem_rdata, 32'h0);
    lat_force = 1;
    imem_addr = 32'h1000_0000; imem_read = 1;
    tick(); chk("rb_next_read", 32'(mem_read), 32'h1);
    tick();
    tick(); chk("rb_next_resp", 32'(imem_resp), 32'h1); chk("rb_next_rdata", imem_rdata, 32'h0000_0013);
    tick(); imem_read = 0;
    tick();

    // randomized traffic
    lat_force = 0; spur_en = 1; rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0; spur_en = 0;
    rst = 1; imem_read = 0; dmem_read = 0; dmem_write = 0; i_got = 0; d_got = 0;
    tick(); rst = 0;

    // both ports held continuously: starvation limiter
    imem_addr = 32'h1000_0000; imem_read = 1;
    dmem_addr = 32'h2000_0000; dmem_read = 1; dmem_write = 0;
    gseq = ""; m_gseq = ""; rec_en = 1;
    for (int i = 0; i < 400 && gseq.len() < 10; i++) tick();
    rec_en = 0;
    exp_seq = "DDDDIDDDDI";
    n_chk++;
    if (gseq != exp_seq) begin
      n_err++; $display("FAIL grant_order: got %s, expected %s", gseq, exp_seq);
    end
    n_chk++;
    if (m_gseq != exp_seq) begin
      n_err++; $display("FAIL model_grant_order: got %s, expected %s", m_gseq, exp_seq);
    end
    imem_read = 0; dmem_read = 0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU instruction-fetch port (imem) and data port (dmem).
- Sits between `cpu` and a single-port memory model, replacing the dual-port magic memory in the top-level bench.
- Handles one outstanding transaction at a time.
- Uses fixed data-over-instruction priority, with a starvation limiter that guarantees fetch progress.

Parameters:
- MAX_D_STREAK, 4: max consecutive dmem grants while an imem request is pending; the next grant is forced to imem. Legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- imem_addr  in  32  fetch address, word-aligned
- imem_read  in  1  fetch request, held until imem_resp
- imem_rdata  out  32  fetch data, valid while imem_resp=1
- imem_resp  out  1  one-cycle fetch completion pulse
- dmem_addr  in  32  data address
- dmem_read  in  1  load request, held until dmem_resp
- dmem_write  in  1  store request, held until dmem_resp
- dmem_wmask  in  4  byte enables for store
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid while dmem_resp=1
- dmem_resp  out  1  one-cycle data completion pulse
- mem_addr  out  32  memory address
- mem_read  out  1  memory read strobe, held until mem_resp
- mem_write  out  1  memory write strobe, held until mem_resp
- mem_wmask  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset
  - State goes to IDLE; streak counter cleared.
  - All outputs are 0, including the rdata registers.
- All outputs are registered.
- States: IDLE, BUSY, DONE.
- IDLE
  - If no request: stay in IDLE; mem_* strobes stay 0.
  - If a request exists, grant by the arbitration rules below.
  - Latch winner id, addr, read/write, wmask and wdata into request registers; go to BUSY.
  - mem_* outputs are driven from these registers starting the next cycle.
- Arbitration
  - Only dmem requesting: grant dmem.
  - Only imem requesting: grant imem.
  - Both requesting: grant dmem, unless streak == MAX_D_STREAK, in which case grant imem.
- Streak counter
  - Increments on a dmem grant made while imem_read=1.
  - Clears on any imem grant.
  - Holds on a dmem grant made while imem_read=0.
  - Saturates at MAX_D_STREAK.
- dmem_read=1 and dmem_write=1 together: treated as a write; mem_read=0.
- dmem_wmask and dmem_wdata are don't-care for loads; mem_wmask is forced to 0 on reads.
- BUSY
  - mem_read or mem_write is held with the latched addr, wmask and wdata, stable until mem_resp.
  - Requester inputs are ignored in this state; changes to them have no effect.
  - On mem_resp=1:
    - Deassert the mem strobe the next cycle.
    - Capture mem_rdata into the winner's rdata register; stores capture 0.
    - Go to DONE.
- DONE
  - Winner's resp=1 for exactly one cycle; the other port's resp=0.
  - Requester inputs are ignored this cycle.
  - Go to IDLE.
  - The requester may drop, or change to a new request, starting the cycle after resp.
- Latency
  - Request seen in IDLE at cycle 0 → mem strobe at cycle 1.
  - With mem_resp at cycle k (k ≥ 1), resp is at cycle k+2.
  - With a 1-cycle memory (mem_resp at cycle 1), resp is at cycle 3.
  - Back-to-back grants: the next mem strobe comes no sooner than 2 cycles after mem_resp.
- rdata registers hold their last value after resp; only the value during resp is specified.
- mem_resp while in IDLE or DONE is ignored.
- Reset mid-transaction (BUSY or DONE)
  - The outstanding transaction is dropped: no resp pulse, strobes deassert the cycle after rst.
  - A late mem_resp after reset is ignored.
- Requests arriving while BUSY are not lost: requesters hold them, and they are evaluated in the next IDLE cycle.

Test Plan:
- Reset: assert rst 2 cycles with imem_read=1 → all outputs 0 throughout; the first mem_read appears the cycle after the first IDLE cycle with rst=0.
- Single fetch: imem_addr=0x1000_0000, 1-cycle memory returning 0x0000_0013 → mem_read=1 with mem_addr=0x1000_0000 for 1 cycle; imem_resp=1 with imem_rdata=0x0000_0013 exactly 3 cycles after the request; dmem_resp stays 0.
- Store: dmem_write=1, addr=0x2000_0004, wmask=4'b0011, wdata=0xDEAD_BEEF, with dmem_read=1 also high → mem_write=1 with matching addr, wmask and wdata; mem_read=0; dmem_resp pulses once.
- Simultaneous requests, MAX_D_STREAK=4: imem and dmem both held continuously, dmem re-requests after every resp → grant order D,D,D,D,I,D,D,D,D,I; imem is never starved beyond 4 data grants.
- Variable latency: mem_resp delayed 7 cycles → mem_addr, mem_wmask and mem_wdata stay stable for all 7 cycles; the resp comes 2 cycles after mem_resp; dmem_addr toggling during BUSY has no effect.
- Reset in BUSY: rst during a pending fetch, then mem_resp one cycle later → no imem_resp pulse, strobes are 0, state is IDLE; the next fetch completes normally.
